// File: rtl/fp_alu_issue_arb_pkg.sv
// Shared types for the FP16 ALU issue arbiter: op codes, arbiter states, FP16 constants.
package fp_alu_pkg;

  typedef enum logic [2:0] {
    FADD     = 3'd0,
    FSUB     = 3'd1,
    FMUL     = 3'd2,
    FMA      = 3'd3,
    FMIN     = 3'd4,
    FMAX     = 3'd5,
    FCVT_I2F = 3'd6,
    FCVT_F2I = 3'd7
  } funct3_e;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    IDLE  = 2'd2
  } arb_state_e;

  localparam logic [15:0] FP16_ONE  = 16'h3C00;
  localparam logic [15:0] FP16_TWO  = 16'h4000;
  localparam logic [15:0] FP16_PINF = 16'h7C00;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;

  // One ALU operation as presented on the issue port.
  typedef struct packed {
    logic [2:0]  funct3;
    logic [15:0] src_a;
    logic [15:0] src_b;
    logic [15:0] src_c;
    logic [31:0] scalar;
    logic [4:0]  rd;
  } alu_op_t;

endpackage

// File: rtl/fp_alu_issue_arb_if.sv
// Bus bundle around the issue arbiter: requester side, ALU side, responses, drain and error status.
interface fp_alu_issue_arb_if #(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0][2:0]   req_funct3;
  logic [NREQ-1:0][15:0]  req_src_a;
  logic [NREQ-1:0][15:0]  req_src_b;
  logic [NREQ-1:0][15:0]  req_src_c;
  logic [NREQ-1:0][31:0]  req_scalar;
  logic [NREQ-1:0][4:0]   req_rd;

  logic        alu_valid;
  logic [2:0]  alu_funct3;
  logic [15:0] alu_src_a;
  logic [15:0] alu_src_b;
  logic [15:0] alu_src_c;
  logic [31:0] alu_scalar;
  logic [4:0]  alu_rd;

  logic        alu_wb_valid;
  logic [4:0]  alu_wb_rd;
  logic [15:0] alu_wb_data;
  logic        alu_wb_scalar_valid;
  logic [31:0] alu_wb_scalar_data;
  logic        alu_wb_err_ovf;
  logic        alu_wb_err_inv;

  logic           resp_valid;
  logic [IDW-1:0] resp_id;
  logic [4:0]     resp_rd;
  logic [15:0]    resp_data;
  logic           resp_scalar_valid;
  logic [31:0]    resp_scalar_data;

  logic            drain_req;
  logic            drain_done;
  logic [NREQ-1:0] err_ovf_sticky;
  logic [NREQ-1:0] err_inv_sticky;
  logic [NREQ-1:0] err_clr;
  logic            tag_mismatch;

  // Arbiter side.
  modport slave (
    input  req_valid, req_funct3, req_src_a, req_src_b, req_src_c, req_scalar, req_rd,
    output req_ready,
    output alu_valid, alu_funct3, alu_src_a, alu_src_b, alu_src_c, alu_scalar, alu_rd,
    input  alu_wb_valid, alu_wb_rd, alu_wb_data, alu_wb_scalar_valid, alu_wb_scalar_data,
    input  alu_wb_err_ovf, alu_wb_err_inv,
    output resp_valid, resp_id, resp_rd, resp_data, resp_scalar_valid, resp_scalar_data,
    input  drain_req, err_clr,
    output drain_done, err_ovf_sticky, err_inv_sticky, tag_mismatch
  );

  // Requester / ALU environment side.
  modport master (
    output req_valid, req_funct3, req_src_a, req_src_b, req_src_c, req_scalar, req_rd,
    input  req_ready,
    input  alu_valid, alu_funct3, alu_src_a, alu_src_b, alu_src_c, alu_scalar, alu_rd,
    output alu_wb_valid, alu_wb_rd, alu_wb_data, alu_wb_scalar_valid, alu_wb_scalar_data,
    output alu_wb_err_ovf, alu_wb_err_inv,
    input  resp_valid, resp_id, resp_rd, resp_data, resp_scalar_valid, resp_scalar_data,
    output drain_req, err_clr,
    input  drain_done, err_ovf_sticky, err_inv_sticky, tag_mismatch
  );

endinterface

// File: rtl/fp_alu_issue_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_id
);

  always_comb begin
    int   idx;
    logic found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/fp_alu_issue_arb.sv
// Shares one fixed-latency FP16 ALU among NREQ requesters: round-robin issue, ID-tagged
// result routing, sticky per-requester error flags and a drain sequencer.
module fp_alu_issue_arb
  import fp_alu_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  fp_alu_issue_arb_if.slave bus
);

  localparam int IDW = $clog2(NREQ);

  arb_state_e state_q, state_d;
  logic [IDW-1:0]              ptr_q;
  logic [NREQ-1:0]             req_elig;
  logic [NREQ-1:0]             grant;
  logic [IDW-1:0]              grant_id;
  alu_op_t                     op_sel;
  logic [ALU_LAT-1:0]          tag_vld;
  logic [ALU_LAT-1:0][IDW-1:0] tag_id;
  logic                        tail_vld;
  logic [IDW-1:0]              tail_id;
  logic                        pipe_empty;
  logic                        resp_fire;
  logic [NREQ-1:0]             set_ovf, set_inv;
  logic [NREQ-1:0]             ovf_q, inv_q;
  logic                        mismatch_q;

  // Only RUN may grant; DRAIN and IDLE hold every requester off.
  assign req_elig = bus.req_valid & {NREQ{state_q == RUN}};

  rr_arbiter #(.N(NREQ)) u_rr (
    .req      (req_elig),
    .ptr      (ptr_q),
    .grant    (grant),
    .grant_id (grant_id)
  );

  always_comb begin
    op_sel = '0;
    if (|grant) begin
      op_sel.funct3 = bus.req_funct3[grant_id];
      op_sel.src_a  = bus.req_src_a[grant_id];
      op_sel.src_b  = bus.req_src_b[grant_id];
      op_sel.src_c  = bus.req_src_c[grant_id];
      op_sel.scalar = bus.req_scalar[grant_id];
      op_sel.rd     = bus.req_rd[grant_id];
    end
  end

  assign bus.req_ready  = grant;
  assign bus.alu_valid  = |grant;
  assign bus.alu_funct3 = op_sel.funct3;
  assign bus.alu_src_a  = op_sel.src_a;
  assign bus.alu_src_b  = op_sel.src_b;
  assign bus.alu_src_c  = op_sel.src_c;
  assign bus.alu_scalar = op_sel.scalar;
  assign bus.alu_rd     = op_sel.rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (bus.alu_valid) begin
      ptr_q <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Tag pipe mirrors the ALU latency so the tail lines up with alu_wb_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= bus.alu_valid;
      tag_id[0]  <= grant_id;
      for (int i = 1; i < ALU_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  assign tail_vld   = tag_vld[ALU_LAT-1];
  assign tail_id    = tag_id[ALU_LAT-1];
  assign pipe_empty = ~|tag_vld;
  assign resp_fire  = tail_vld & bus.alu_wb_valid;

  assign bus.resp_valid        = resp_fire;
  assign bus.resp_id           = tail_id;
  assign bus.resp_rd           = bus.alu_wb_rd;
  assign bus.resp_data         = bus.alu_wb_data;
  assign bus.resp_scalar_valid = resp_fire & bus.alu_wb_scalar_valid;
  assign bus.resp_scalar_data  = bus.alu_wb_scalar_data;

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.drain_req) state_d = DRAIN;
      DRAIN:   if (pipe_empty)    state_d = IDLE;
      IDLE:    if (!bus.drain_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign bus.drain_done = (state_q == IDLE);

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      set_ovf[i] = resp_fire & bus.alu_wb_err_ovf & (tail_id == IDW'(i));
      set_inv[i] = resp_fire & bus.alu_wb_err_inv & (tail_id == IDW'(i));
    end
  end

  // A new error in the same cycle as its W1C keeps the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q      <= '0;
      inv_q      <= '0;
      mismatch_q <= 1'b0;
    end else begin
      ovf_q      <= (ovf_q & ~bus.err_clr) | set_ovf;
      inv_q      <= (inv_q & ~bus.err_clr) | set_inv;
      mismatch_q <= mismatch_q | (tail_vld != bus.alu_wb_valid);
    end
  end

  assign bus.err_ovf_sticky = ovf_q;
  assign bus.err_inv_sticky = inv_q;
  assign bus.tag_mismatch   = mismatch_q;

endmodule
